awaddr_axi_issuer: RTL and testbench
====================================

AWADDR_AXI_ISSUER -- requirements
Module: awaddr_axi_issuer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning width of FIFO entry and of m_awaddr.
REQ-002 SHALL have parameter AW_LEN, default 8'd15, meaning constant value driven on m_awlen (16-beat bursts).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, range 1..15, meaning maximum issued-but-unresponded bursts.
REQ-004 SHALL have ports as follows; one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 fifo_rd_data  input  ADDR_WIDTH  write-address FIFO read data, valid the cycle after fifo_rd_en (non-registered FIFO output).
REQ-008 fifo_rd_empty  input  1  write-address FIFO empty.
REQ-009 fifo_rd_en  output  1  one-cycle pop strobe to write-address FIFO.
REQ-010 m_awaddr  output  ADDR_WIDTH  AXI write address.
REQ-011 m_awlen  output  8  AXI burst length, constant AW_LEN.
REQ-012 m_awvalid  output  1  AXI AW valid.
REQ-013 m_awready  input  1  AXI AW ready.
REQ-014 m_bvalid  input  1  AXI B response valid.
REQ-015 m_bresp  input  2  AXI B response code.
REQ-016 m_bready  output  1  AXI B ready.
REQ-017 outstanding  output  4  count of bursts issued and awaiting B response.
REQ-018 aw_issued_cnt  output  16  total AW handshakes since reset, wraps 0xFFFF->0x0000.
REQ-019 resp_err  output  1  sticky: non-OKAY bresp or B response with outstanding==0.

Function
REQ-020 SHALL implement FSM states IDLE, POP, LOAD, ISSUE.
REQ-021 IDLE -> POP when fifo_rd_empty==0 and outstanding<MAX_OUTSTANDING; otherwise remain IDLE.
REQ-022 POP: fifo_rd_en=1 for exactly this one cycle; -> LOAD unconditionally.
REQ-023 LOAD: m_awaddr <= fifo_rd_data; -> ISSUE; m_awvalid=1 from the first ISSUE cycle.
REQ-024 ISSUE: hold m_awvalid=1 and m_awaddr stable until m_awready==1; on handshake -> IDLE, m_awvalid=0 next cycle.
REQ-025 fifo_rd_en SHALL never assert in any state other than POP; at most one pop per issued burst.
REQ-026 Minimum spacing between consecutive AW handshakes SHALL be 4 cycles (IDLE, POP, LOAD, ISSUE).
REQ-027 m_awlen SHALL equal AW_LEN at all times including reset.
REQ-028 m_bready SHALL be 1 when outstanding>0, else 0.
REQ-029 outstanding: +1 on AW handshake, -1 on m_bvalid&&m_bready; both in same cycle -> unchanged.
REQ-030 outstanding SHALL never exceed MAX_OUTSTANDING nor underflow below 0.
REQ-031 m_bvalid with outstanding==0 SHALL not change outstanding and SHALL set resp_err.
REQ-032 m_bvalid&&m_bready with m_bresp!=2'b00 SHALL set resp_err; the counter still decrements.
REQ-033 aw_issued_cnt SHALL increment by 1 on every AW handshake, modulo 2^16.
REQ-034 fifo_rd_empty SHALL be sampled only in IDLE; changes in other states are ignored.

Reset
REQ-035 While rst==1 at a clk rising edge: state=IDLE, fifo_rd_en=0, m_awvalid=0, m_awaddr=0, outstanding=0, aw_issued_cnt=0, resp_err=0, m_bready=0.
REQ-036 Reset asserted mid-ISSUE SHALL drop m_awvalid the next cycle and discard the held address; no implicit re-pop after reset.
REQ-037 First pop after reset deassertion SHALL occur no earlier than the second clk edge after rst falls.

Verification
REQ-038 Single entry: push 0x0000_1000, m_awready=1 -> one fifo_rd_en pulse, m_awaddr=0x0000_1000 with m_awvalid for 1 cycle, outstanding=1, aw_issued_cnt=1.
REQ-039 Backpressure: m_awready=0 for 10 cycles then 1 -> m_awvalid held 11 cycles, m_awaddr stable, no extra fifo_rd_en.
REQ-040 Outstanding limit: 6 entries queued, no B responses -> exactly 4 AW handshakes, outstanding=4, fifo_rd_en idle; one B response -> 5th issued.
REQ-041 Simultaneous: AW handshake and B handshake in same cycle with outstanding=2 -> outstanding stays 2.
REQ-042 Errors: bresp=2'b10 -> resp_err=1 and sticky; m_bvalid at outstanding=0 -> resp_err=1, outstanding stays 0.
REQ-043 Reset mid-ISSUE: rst=1 while m_awvalid=1 -> all outputs at REQ-035 values next cycle; FIFO remaining entries issued in order after release.

Source files
------------

// File: rtl/awaddr_axi_issuer.sv
// AXI write-address issuer: pops burst start addresses from a FIFO with a
// non-registered read port and issues them as fixed-length AW bursts. The
// number of bursts awaiting a B response is capped at MAX_OUTSTANDING.
// MAX_OUTSTANDING must lie in 1..15 so that it fits the 4-bit counter.
module awaddr_axi_issuer #(
  parameter int         ADDR_WIDTH      = 32,
  parameter logic [7:0] AW_LEN          = 8'd15,
  parameter int         MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  fifo_rd_en,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  input  logic                  m_bvalid,
  input  logic [1:0]            m_bresp,
  output logic                  m_bready,
  output logic [3:0]            outstanding,
  output logic [15:0]           aw_issued_cnt,
  output logic                  resp_err
);

  typedef enum logic [1:0] {
    ST_IDLE,   // wait for an entry and for room in the outstanding window
    ST_POP,    // one-cycle pop strobe to the FIFO
    ST_LOAD,   // FIFO data is valid now; capture it into the address register
    ST_ISSUE   // present the address until the slave accepts it
  } state_e;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [3:0]              out_q, out_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic                    aw_hs;
  logic                    b_hs;
  logic                    has_room;

  // Handshake qualifiers shared by the FSM and the bookkeeping logic.
  always_comb begin
    m_bready = (out_q != 4'd0);
    aw_hs    = (state_q == ST_ISSUE) && m_awready;
    b_hs     = m_bvalid && m_bready;
    has_room = (out_q < MAX_OUT);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the state-decoded handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    m_awvalid  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The empty flag is only looked at here; it is a don't-care elsewhere.
        if (!fifo_rd_empty && has_room) begin
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        // Gated by rst so a reset landing on the POP cycle cannot lose an entry.
        fifo_rd_en = !rst;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        m_awvalid = 1'b1;
        if (m_awready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values for the address register and the bookkeeping counters.
  always_comb begin
    awaddr_d = awaddr_q;
    if (state_q == ST_LOAD) begin
      awaddr_d = fifo_rd_data;
    end

    out_d = out_q;
    unique case ({aw_hs, b_hs})
      2'b10:   out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase

    cnt_d = aw_hs ? cnt_q + 16'd1 : cnt_q;

    // A response with nothing outstanding is never accepted (bready is low),
    // so it cannot underflow the counter; it only raises the error flag.
    err_d = err_q
          | (b_hs && (m_bresp != 2'b00))
          | (m_bvalid && (out_q == 4'd0));
  end

  // Address register and counters; reset discards any held address.
  always_ff @(posedge clk) begin
    if (rst) begin
      awaddr_q <= '0;
      out_q    <= 4'd0;
      cnt_q    <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      awaddr_q <= awaddr_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign m_awaddr      = awaddr_q;
  assign m_awlen       = AW_LEN;
  assign outstanding   = out_q;
  assign aw_issued_cnt = cnt_q;
  assign resp_err      = err_q;

endmodule

// File: tb/tb_awaddr_axi_issuer.sv
// Self-checking bench for awaddr_axi_issuer: directed scenarios followed by a
// randomized run, all checked against a transaction-level model (FIFO queue,
// in-flight address queue, outstanding/issued counters, sticky error).
module tb_awaddr_axi_issuer;

  localparam int         AW   = 32;
  localparam int         MAXO = 4;
  localparam logic [7:0] LEN  = 8'd15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty = 1'b1;
  logic          fifo_rd_en;
  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic          m_awvalid;
  logic          m_awready = 1'b0;
  logic          m_bvalid = 1'b0;
  logic [1:0]    m_bresp = 2'b00;
  logic          m_bready;
  logic [3:0]    outstanding;
  logic [15:0]   aw_issued_cnt;
  logic          resp_err;

  awaddr_axi_issuer #(
    .ADDR_WIDTH(AW),
    .AW_LEN(LEN),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_en(fifo_rd_en),
    .m_awaddr(m_awaddr),
    .m_awlen(m_awlen),
    .m_awvalid(m_awvalid),
    .m_awready(m_awready),
    .m_bvalid(m_bvalid),
    .m_bresp(m_bresp),
    .m_bready(m_bready),
    .outstanding(outstanding),
    .aw_issued_cnt(aw_issued_cnt),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [AW-1:0] fifo_q[$];     // entries still inside the FIFO
  logic [AW-1:0] popped_q[$];   // popped, not yet issued on AW
  int            m_out = 0;
  int            m_cnt = 0;
  bit            m_err = 1'b0;
  int            cyc = 0;
  int            last_hs = -100;
  int            n_pop = 0;
  int            n_hs = 0;
  int            n_valid = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [AW-1:0] a);
    fifo_q.push_back(a);
    fifo_rd_empty = 1'b0;
  endtask

  // One clock cycle: called at a negedge with inputs already driven.
  task automatic step();
    bit            aw_hs, b_hs, b_stray, rd, hold, rst_edge;
    logic [1:0]    bresp;
    logic [AW-1:0] addr;
    aw_hs    = (m_awvalid === 1'b1) && m_awready;
    b_hs     = m_bvalid && (m_out > 0);
    b_stray  = m_bvalid && (m_out == 0);
    rd       = (fifo_rd_en === 1'b1);
    hold     = (m_awvalid === 1'b1) && !m_awready && !rst;
    rst_edge = rst;
    bresp    = m_bresp;
    addr     = m_awaddr;
    if (m_awvalid === 1'b1) n_valid++;
    if (rd) n_pop++;
    check("rd_en_with_valid", 64'(fifo_rd_en && m_awvalid), 64'd0);
    if (aw_hs && !rst) begin
      n_hs++;
      check("hs_spacing_ok", 64'((cyc - last_hs) >= 4), 64'd1);
      check("hs_has_popped_entry", 64'(popped_q.size()), 64'd1);
      if (popped_q.size() > 0) check("aw_addr", 64'(addr), 64'(popped_q.pop_front()));
      last_hs = cyc;
    end

    @(posedge clk);
    cyc++;
    #1;
    if (rd) begin
      check("pop_nonempty", 64'(fifo_q.size() > 0), 64'd1);
      if (fifo_q.size() > 0) begin
        fifo_rd_data = fifo_q.pop_front();
        popped_q.push_back(fifo_rd_data);
      end
    end else begin
      fifo_rd_data = $urandom;
    end
    fifo_rd_empty = (fifo_q.size() == 0);

    if (rst_edge) begin
      m_out   = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
      last_hs = -100;
      popped_q.delete();
    end else begin
      if (aw_hs) begin
        m_out++;
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (b_hs) begin
        m_out--;
        if (bresp != 2'b00) m_err = 1'b1;
      end
      if (b_stray) m_err = 1'b1;
    end
    check("one_pop_per_burst", 64'(popped_q.size() <= 1), 64'd1);

    @(negedge clk);
    check("outstanding", 64'(outstanding), 64'(m_out));
    check("bready", 64'(m_bready), 64'(m_out > 0));
    check("resp_err", 64'(resp_err), 64'(m_err));
    check("aw_issued_cnt", 64'(aw_issued_cnt), 64'(m_cnt));
    check("awlen", 64'(m_awlen), 64'(LEN));
    check("outstanding_max", 64'(outstanding <= MAXO), 64'd1);
    if (rst_edge) begin
      check("rst_awvalid", 64'(m_awvalid), 64'd0);
      check("rst_awaddr", 64'(m_awaddr), 64'd0);
    end
    if (rst) check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    if (hold) begin
      check("hold_valid", 64'(m_awvalid), 64'd1);
      check("hold_addr", 64'(m_awaddr), 64'(addr));
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (m_awvalid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("wait_awvalid_in_budget", 64'(m_awvalid), 64'd1);
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);
    repeat (3) step();
    check("reset_outstanding", 64'(outstanding), 64'd0);
    check("reset_awvalid", 64'(m_awvalid), 64'd0);

    // Single entry, queued while still in reset.
    push(32'h0000_1000);
    rst = 1'b0;
    check("first_pop_not_at_first_edge", 64'(fifo_rd_en), 64'd0);
    m_awready = 1'b1;
    n_pop = 0; n_valid = 0; n_hs = 0;
    repeat (8) step();
    check("single_pops", 64'(n_pop), 64'd1);
    check("single_valid_cycles", 64'(n_valid), 64'd1);
    check("single_hs", 64'(n_hs), 64'd1);
    check("single_out", 64'(outstanding), 64'd1);
    check("single_cnt", 64'(aw_issued_cnt), 64'd1);
    m_bvalid = 1'b1; step(); m_bvalid = 1'b0;

    // Backpressure: ready low for 10 cycles of valid, then high.
    m_awready = 1'b0;
    n_pop = 0;
    push(32'h0000_2000);
    wait_valid(10);
    n_valid = 0;
    repeat (10) step();
    m_awready = 1'b1; step();
    m_awready = 1'b0; step();
    check("bp_valid_cycles", 64'(n_valid), 64'd11);
    check("bp_pops", 64'(n_pop), 64'd1);
    m_bvalid = 1'b1; step(); m_bvalid = 1'b0;

    // Outstanding limit: six entries, no responses.
    m_awready = 1'b1;
    n_hs = 0;
    for (int i = 0; i < 6; i++) push(32'h0000_3000 + 32'(i * 16));
    repeat (30) step();
    check("lim_hs", 64'(n_hs), 64'd4);
    check("lim_out", 64'(outstanding), 64'(MAXO));
    check("lim_left_in_fifo", 64'(fifo_q.size()), 64'd2);
    n_pop = 0;
    repeat (10) step();
    check("lim_no_pops", 64'(n_pop), 64'd0);
    m_bvalid = 1'b1; step(); m_bvalid = 1'b0;
    repeat (8) step();
    check("lim_fifth_hs", 64'(n_hs), 64'd5);
    check("lim_out_again", 64'(outstanding), 64'(MAXO));

    // Simultaneous AW and B handshakes at outstanding == 2.
    m_awready = 1'b0;
    m_bvalid = 1'b1; step(); step(); m_bvalid = 1'b0;
    wait_valid(10);
    check("sim_pre_out", 64'(outstanding), 64'd2);
    m_awready = 1'b1; m_bvalid = 1'b1; step();
    m_awready = 1'b0; m_bvalid = 1'b0;
    check("sim_out", 64'(outstanding), 64'd2);

    // Error response is sticky and still retires the burst.
    m_bvalid = 1'b1; m_bresp = 2'b10; step();
    m_bresp = 2'b00; step(); m_bvalid = 1'b0;
    check("err_slverr", 64'(resp_err), 64'd1);
    check("err_drained", 64'(outstanding), 64'd0);
    repeat (5) step();
    check("err_sticky", 64'(resp_err), 64'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("err_cleared", 64'(resp_err), 64'd0);
    m_bvalid = 1'b1; step(); m_bvalid = 1'b0;
    check("stray_b_err", 64'(resp_err), 64'd1);
    check("stray_b_out", 64'(outstanding), 64'd0);

    // Reset while an address is being presented.
    rst = 1'b1; step(); rst = 1'b0;
    m_awready = 1'b0;
    push(32'h0000_A000); push(32'h0000_B000); push(32'h0000_C000);
    wait_valid(10);
    check("rmi_held_addr", 64'(m_awaddr), 64'h0000_A000);
    rst = 1'b1; step(); rst = 1'b0;
    check("rmi_valid_dropped", 64'(m_awvalid), 64'd0);
    m_awready = 1'b1;
    n_hs = 0;
    repeat (12) step();
    check("rmi_hs", 64'(n_hs), 64'd2);
    check("rmi_cnt", 64'(aw_issued_cnt), 64'd2);
    check("rmi_fifo_empty", 64'(fifo_q.size()), 64'd0);
    m_bvalid = 1'b1; repeat (2) step(); m_bvalid = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      m_awready = ($urandom_range(0, 3) != 0);
      m_bvalid  = ($urandom_range(0, 3) == 0);
      m_bresp   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 5) == 0 && fifo_q.size() < 8) push($urandom);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; m_bvalid = 1'b0; m_awready = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
